bus_arb_wb: RTL and testbench

BUS_ARB_WB -- requirements
Module: bus_arb_wb

---
 rtl/bus_arb_wb_pkg.sv | 20 ++
 rtl/bus_arb_wb_if.sv | 30 +++
 rtl/bus_arb_wb_rr_pick.sv | 42 ++++
 rtl/bus_arb_wb.sv | 184 ++++++++++++++++++
 tb/tb_bus_arb_wb.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arb_wb_pkg.sv
// bus_arb_wb_pkg
// Shared definitions for the Wishbone bus arbiter: FSM state encodings,
// the default ack timeout and a small byte-lane helper.
// No ports (package).
package bus_arb_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CYC1 = 2'd1,
      ST_CYC2 = 2'd2
   } state_t;

   localparam int TMO_DEFAULT = 255;

   // Byte transfers drive the same byte on both data lanes.
   function automatic logic [15:0] byte_lane(input logic [7:0] b);
      return {b, b};
   endfunction

endpackage

// File: rtl/bus_arb_wb_if.sv
// bus_arb_wb_if
// Wishbone master-side bus between the arbiter and the downstream slave.
// Signals: adr_o, dat_o, we_o, mio_o, byte_o, stb_o, cyc_o (arbiter -> slave),
//          dat_i, ack_i (slave -> arbiter).
// Modports: master (arbiter side), slave (memory/IO side).
interface bus_arb_wb_if #(
   parameter int AW = 20
) ();

   logic [AW-1:0] adr_o;
   logic [15:0]   dat_o;
   logic          we_o;
   logic          mio_o;
   logic          byte_o;
   logic          stb_o;
   logic          cyc_o;
   logic [15:0]   dat_i;
   logic          ack_i;

   modport master (
      output adr_o, dat_o, we_o, mio_o, byte_o, stb_o, cyc_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  adr_o, dat_o, we_o, mio_o, byte_o, stb_o, cyc_o,
      output dat_i, ack_i
   );

endinterface

// File: rtl/bus_arb_wb_rr_pick.sv
// rr_pick
// Combinational winner selection. The search starts at the channel after
// 'last' and wraps; fixed-priority mode simply pins the start point so the
// search always begins at channel 0.
// Ports: req (channel requests), last (last granted index),
//        any (some request active), idx (winner index), onehot (winner mask).
module rr_pick #(
   parameter int NCH     = 2,
   parameter int PRIO_RR = 0,
   parameter int IW      = 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last,
   output logic           any,
   output logic [IW-1:0]  idx,
   output logic [NCH-1:0] onehot
);

   int             base_s;
   int             k_s;
   logic           hit_s;
   logic [NCH-1:0] req_sh_s;

   // Scan channels starting after the base; the first active one wins.
   always_comb begin
      base_s   = (PRIO_RR != 0) ? int'(last) : (NCH - 1);
      any      = 1'b0;
      idx      = '0;
      k_s      = 0;
      hit_s    = 1'b0;
      req_sh_s = '0;
      for (int off = 1; off <= NCH; off++) begin
         k_s      = (base_s + off) % NCH;
         req_sh_s = req >> k_s;
         hit_s    = ~any & req_sh_s[0];
         idx      = hit_s ? IW'(k_s) : idx;
         any      = any | hit_s;
      end
      onehot = any ? (NCH'(1) << idx) : '0;
   end

endmodule

// File: rtl/bus_arb_wb.sv
// bus_arb_wb
// Arbitrates NCH requesting channels onto one 16-bit Wishbone master port.
// Unaligned word accesses are split into two byte cycles with a one-cycle
// strobe gap; an optional ack timeout aborts a stuck cycle with err_o.
// Ports: clk_i, rst_i (async active-low), req_i, cadr_i, cdat_i, cwe_i,
//        cbyte_i, cmio_i (per-channel request side), gnt_o, done_o, err_o,
//        rdat_o (per-channel response side), wb (Wishbone master modport).
module bus_arb_wb
   import bus_arb_wb_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 20,
   parameter int PRIO_RR = 0,
   parameter int TMO     = TMO_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NCH-1:0]    req_i,
   input  logic [NCH*AW-1:0] cadr_i,
   input  logic [NCH*16-1:0] cdat_i,
   input  logic [NCH-1:0]    cwe_i,
   input  logic [NCH-1:0]    cbyte_i,
   input  logic [NCH-1:0]    cmio_i,
   output logic [NCH-1:0]    gnt_o,
   output logic [NCH-1:0]    done_o,
   output logic [NCH-1:0]    err_o,
   output logic [15:0]       rdat_o,
   bus_arb_wb_if.master      wb
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

   state_t         state_r, state_s;
   logic [IW-1:0]  last_r;
   logic [NCH-1:0] gnt_r, done_r, err_r;
   logic [15:0]    rdat_r, dat_r;
   logic [AW-1:0]  adr_r;
   logic [7:0]     wdat_hi_r, lo_r;
   logic           we_r, mio_r, byte_r, split_r, stb_r, cyc_r;
   logic [TW-1:0]  tmo_cnt_r;

   logic           pick_any_s;
   logic [IW-1:0]  pick_idx_s;
   logic [NCH-1:0] pick_oh_s;
   logic [AW-1:0]  sel_adr_s;
   logic [15:0]    sel_dat_s;
   logic           sel_byte_s;
   logic           start_s, ack_s, fin_s, tmo_hit_s;

   rr_pick #(
      .NCH     (NCH),
      .PRIO_RR (PRIO_RR),
      .IW      (IW)
   ) u_pick (
      .req    (req_i),
      .last   (last_r),
      .any    (pick_any_s),
      .idx    (pick_idx_s),
      .onehot (pick_oh_s)
   );

   assign sel_adr_s  = cadr_i[int'(pick_idx_s) * AW +: AW];
   assign sel_dat_s  = cdat_i[int'(pick_idx_s) * 16 +: 16];
   assign sel_byte_s = cbyte_i[pick_idx_s];

   // No arbitration in the done/err cycle: the old owner still holds req_i.
   assign start_s   = (state_r == ST_IDLE) & pick_any_s & ~(|done_r) & ~(|err_r);
   assign ack_s     = stb_r & wb.ack_i;
   assign fin_s     = ack_s & ((state_r == ST_CYC2) | ~split_r);
   assign tmo_hit_s = (TMO != 0) & stb_r & ~wb.ack_i & (tmo_cnt_r == TW'(TMO - 1));

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_s = ST_CYC1;
            else         state_s = ST_IDLE;
         end
         ST_CYC1: begin
            if (tmo_hit_s)  state_s = ST_IDLE;
            else if (ack_s) state_s = split_r ? ST_CYC2 : ST_IDLE;
            else            state_s = ST_CYC1;
         end
         ST_CYC2: begin
            if (tmo_hit_s || ack_s) state_s = ST_IDLE;
            else                    state_s = ST_CYC2;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Grant, bus output, read assembly and timeout registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_r    <= IW'(NCH - 1);
         gnt_r     <= '0;
         done_r    <= '0;
         err_r     <= '0;
         rdat_r    <= 16'h0000;
         dat_r     <= 16'h0000;
         adr_r     <= '0;
         wdat_hi_r <= 8'h00;
         lo_r      <= 8'h00;
         we_r      <= 1'b0;
         mio_r     <= 1'b0;
         byte_r    <= 1'b0;
         split_r   <= 1'b0;
         stb_r     <= 1'b0;
         cyc_r     <= 1'b0;
         tmo_cnt_r <= '0;
      end else begin
         done_r <= '0;
         err_r  <= '0;
         if (start_s) begin
            gnt_r     <= pick_oh_s;
            last_r    <= pick_idx_s;
            adr_r     <= sel_adr_s;
            // Byte ops and the first half of a split both send the low byte.
            dat_r     <= (sel_byte_s | sel_adr_s[0]) ? byte_lane(sel_dat_s[7:0]) : sel_dat_s;
            wdat_hi_r <= sel_dat_s[15:8];
            we_r      <= cwe_i[pick_idx_s];
            mio_r     <= cmio_i[pick_idx_s];
            byte_r    <= sel_byte_s | sel_adr_s[0];
            split_r   <= ~sel_byte_s & sel_adr_s[0];
            stb_r     <= 1'b1;
            cyc_r     <= 1'b1;
            tmo_cnt_r <= '0;
         end else if (tmo_hit_s) begin
            err_r     <= gnt_r;
            gnt_r     <= '0;
            stb_r     <= 1'b0;
            cyc_r     <= 1'b0;
            tmo_cnt_r <= '0;
         end else if (fin_s) begin
            done_r    <= gnt_r;
            gnt_r     <= '0;
            stb_r     <= 1'b0;
            cyc_r     <= 1'b0;
            tmo_cnt_r <= '0;
            if (!we_r) begin
               if (split_r)     rdat_r <= {wb.dat_i[7:0], lo_r};
               else if (byte_r) rdat_r <= {8'h00, wb.dat_i[7:0]};
               else             rdat_r <= wb.dat_i;
            end
         end else if (ack_s) begin
            // First half of a split: keep cyc, drop stb for the gap cycle.
            lo_r      <= wb.dat_i[7:0];
            adr_r     <= adr_r + AW'(1);
            dat_r     <= byte_lane(wdat_hi_r);
            stb_r     <= 1'b0;
            tmo_cnt_r <= '0;
         end else if ((state_r == ST_CYC2) && !stb_r) begin
            stb_r     <= 1'b1;
            tmo_cnt_r <= '0;
         end else if (stb_r) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
         end
      end
   end

   assign gnt_o     = gnt_r;
   assign done_o    = done_r;
   assign err_o     = err_r;
   assign rdat_o    = rdat_r;
   assign wb.adr_o  = adr_r;
   assign wb.dat_o  = dat_r;
   assign wb.we_o   = we_r;
   assign wb.mio_o  = mio_r;
   assign wb.byte_o = byte_r;
   assign wb.stb_o  = stb_r;
   assign wb.cyc_o  = cyc_r;

endmodule

// File: tb/tb_bus_arb_wb.sv
// tb_bus_arb_wb
// Directed bench: instance A is fixed priority, NCH=2, TMO=4; instance B is
// round-robin, NCH=3, timeout disabled. Table-driven transactions on A, then
// hand-written timeout, round-robin and mid-transaction reset sequences.
module tb_bus_arb_wb;

   localparam int AW = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   // Instance A
   logic [1:0]      a_req, a_we, a_byte, a_mio, a_gnt, a_done, a_err;
   logic [2*AW-1:0] a_adr;
   logic [31:0]     a_cdat;
   logic [15:0]     a_rdat;
   bus_arb_wb_if #(.AW(AW)) a_wb ();

   bus_arb_wb #(.NCH(2), .AW(AW), .PRIO_RR(0), .TMO(4)) u_a (
      .clk_i(clk), .rst_i(rst_n), .req_i(a_req), .cadr_i(a_adr), .cdat_i(a_cdat),
      .cwe_i(a_we), .cbyte_i(a_byte), .cmio_i(a_mio), .gnt_o(a_gnt),
      .done_o(a_done), .err_o(a_err), .rdat_o(a_rdat), .wb(a_wb)
   );

   // Instance B
   logic [2:0]      b_req, b_we, b_byte, b_mio, b_gnt, b_done, b_err;
   logic [3*AW-1:0] b_adr;
   logic [47:0]     b_cdat;
   logic [15:0]     b_rdat;
   bus_arb_wb_if #(.AW(AW)) b_wb ();

   bus_arb_wb #(.NCH(3), .AW(AW), .PRIO_RR(1), .TMO(0)) u_b (
      .clk_i(clk), .rst_i(rst_n), .req_i(b_req), .cadr_i(b_adr), .cdat_i(b_cdat),
      .cwe_i(b_we), .cbyte_i(b_byte), .cmio_i(b_mio), .gnt_o(b_gnt),
      .done_o(b_done), .err_o(b_err), .rdat_o(b_rdat), .wb(b_wb)
   );

   typedef struct {
      logic [1:0]  req;
      int          ch;
      logic [19:0] adr;
      logic [15:0] wdat;
      logic        we;
      logic        bt;
      logic        mio;
      logic [15:0] rd0;
      logic [15:0] rd1;
      int          lat;
      logic        split;
      logic        e_byte;
      logic [15:0] dat1;
      logic [19:0] adr2;
      logic [15:0] dat2;
      logic [15:0] rdat;
   } vec_t;

   vec_t       tbl [7];
   logic [2:0] ord [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_stb_a(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_wb.stb_o && n < 8);
   endtask

   task automatic wait_stb_b(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b_wb.stb_o && n < 8);
   endtask

   // Runs one table transaction on instance A, starting and ending on a negedge.
   task automatic a_run(input vec_t v);
      int n;
      a_req                  = v.req;
      a_adr[v.ch*AW +: AW]   = v.adr;
      a_cdat[v.ch*16 +: 16]  = v.wdat;
      a_we[v.ch]             = v.we;
      a_byte[v.ch]           = v.bt;
      a_mio[v.ch]            = v.mio;
      wait_stb_a(n);
      chk("a_latency", n, v.lat);
      chk("a_gnt", a_gnt, 2'b01 << v.ch);
      chk("a_adr1", a_wb.adr_o, v.adr);
      chk("a_dat1", a_wb.dat_o, v.dat1);
      chk("a_byte1", a_wb.byte_o, v.e_byte);
      chk("a_we", a_wb.we_o, v.we);
      chk("a_mio", a_wb.mio_o, v.mio);
      chk("a_cyc", a_wb.cyc_o, 1'b1);
      a_wb.dat_i = v.rd0;
      a_wb.ack_i = 1'b1;
      @(negedge clk);
      a_wb.ack_i = 1'b0;
      if (v.split) begin
         chk("a_gap_stb", a_wb.stb_o, 1'b0);
         chk("a_gap_done", a_done, 2'b00);
         @(negedge clk);
         chk("a_stb2", a_wb.stb_o, 1'b1);
         chk("a_adr2", a_wb.adr_o, v.adr2);
         chk("a_dat2", a_wb.dat_o, v.dat2);
         chk("a_byte2", a_wb.byte_o, 1'b1);
         a_wb.dat_i = v.rd1;
         a_wb.ack_i = 1'b1;
         @(negedge clk);
         a_wb.ack_i = 1'b0;
      end
      chk("a_done", a_done, 2'b01 << v.ch);
      chk("a_gnt_clr", a_gnt, 2'b00);
      chk("a_stb_clr", a_wb.stb_o, 1'b0);
      chk("a_err", a_err, 2'b00);
      if (!v.we) chk("a_rdat", a_rdat, v.rdat);
      a_req[v.ch] = 1'b0;
   endtask

   initial begin
      int n;
      int cnt;
      a_req = '0; a_adr = '0; a_cdat = '0; a_we = '0; a_byte = '0; a_mio = '0;
      b_req = '0; b_adr = '0; b_cdat = '0; b_we = '0; b_byte = '0; b_mio = '0;
      a_wb.dat_i = 16'h0000; a_wb.ack_i = 1'b0;
      b_wb.dat_i = 16'h0000; b_wb.ack_i = 1'b0;

      tbl[0] = '{req:2'b11, ch:0, adr:20'h00100, wdat:16'h0000, we:1'b0, bt:1'b0, mio:1'b1,
                 rd0:16'hBEEF, rd1:16'h0000, lat:1, split:1'b0, e_byte:1'b0,
                 dat1:16'h0000, adr2:20'h00000, dat2:16'h0000, rdat:16'hBEEF};
      tbl[1] = '{req:2'b10, ch:1, adr:20'h00201, wdat:16'h1234, we:1'b1, bt:1'b0, mio:1'b0,
                 rd0:16'h0000, rd1:16'h0000, lat:2, split:1'b1, e_byte:1'b1,
                 dat1:16'h3434, adr2:20'h00202, dat2:16'h1212, rdat:16'h0000};
      tbl[2] = '{req:2'b01, ch:0, adr:20'hFFFFF, wdat:16'h0000, we:1'b0, bt:1'b0, mio:1'b1,
                 rd0:16'h00AB, rd1:16'h00CD, lat:2, split:1'b1, e_byte:1'b1,
                 dat1:16'h0000, adr2:20'h00000, dat2:16'h0000, rdat:16'hCDAB};
      tbl[3] = '{req:2'b10, ch:1, adr:20'h00300, wdat:16'h77C3, we:1'b1, bt:1'b1, mio:1'b0,
                 rd0:16'h0000, rd1:16'h0000, lat:2, split:1'b0, e_byte:1'b1,
                 dat1:16'hC3C3, adr2:20'h00000, dat2:16'h0000, rdat:16'h0000};
      tbl[4] = '{req:2'b01, ch:0, adr:20'h00401, wdat:16'h9988, we:1'b0, bt:1'b1, mio:1'b1,
                 rd0:16'h5566, rd1:16'h0000, lat:2, split:1'b0, e_byte:1'b1,
                 dat1:16'h8888, adr2:20'h00000, dat2:16'h0000, rdat:16'h0066};
      tbl[5] = '{req:2'b10, ch:1, adr:20'h00402, wdat:16'hA5F0, we:1'b1, bt:1'b0, mio:1'b1,
                 rd0:16'h0000, rd1:16'h0000, lat:2, split:1'b0, e_byte:1'b0,
                 dat1:16'hA5F0, adr2:20'h00000, dat2:16'h0000, rdat:16'h0000};
      tbl[6] = '{req:2'b11, ch:0, adr:20'h00010, wdat:16'h0000, we:1'b0, bt:1'b0, mio:1'b0,
                 rd0:16'h1357, rd1:16'h0000, lat:2, split:1'b0, e_byte:1'b0,
                 dat1:16'h0000, adr2:20'h00000, dat2:16'h0000, rdat:16'h1357};
      ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100; ord[3] = 3'b001;

      // Reset state
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_stb", a_wb.stb_o, 1'b0);
      chk("rst_cyc", a_wb.cyc_o, 1'b0);
      chk("rst_adr", a_wb.adr_o, 20'h00000);
      chk("rst_dat", a_wb.dat_o, 16'h0000);
      chk("rst_gnt", a_gnt, 2'b00);
      chk("rst_rdat", a_rdat, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven transactions on the fixed-priority instance
      for (int i = 0; i < 7; i++) a_run(tbl[i]);
      a_req = 2'b00;
      @(negedge clk);

      // Timeout: no ack for 4 strobe cycles
      a_req = 2'b01;
      a_adr[0 +: AW] = 20'h00050;
      a_we[0] = 1'b0;
      a_byte[0] = 1'b0;
      wait_stb_a(n);
      chk("tmo_latency", n, 1);
      cnt = 0;
      while (a_wb.stb_o && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      chk("tmo_strobe_cycles", cnt, 4);
      chk("tmo_err", a_err, 2'b01);
      chk("tmo_done", a_done, 2'b00);
      chk("tmo_gnt", a_gnt, 2'b00);
      chk("tmo_rdat", a_rdat, 16'h1357);
      a_req = 2'b00;
      @(negedge clk);
      chk("tmo_err_pulse", a_err, 2'b00);

      // Stray ack while idle
      a_wb.ack_i = 1'b1;
      @(negedge clk);
      a_wb.ack_i = 1'b0;
      chk("idle_ack_done", a_done, 2'b00);
      chk("idle_ack_stb", a_wb.stb_o, 1'b0);

      // Round-robin order with all requests held
      b_adr = {20'h00020, 20'h00010, 20'h00000};
      b_req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_stb_b(n);
         chk("rr_gnt", b_gnt, ord[i]);
         chk("rr_adr", b_wb.adr_o, 32'(i % 3) * 32'h10);
         b_wb.dat_i = 16'h1000 + 16'(i);
         b_wb.ack_i = 1'b1;
         @(negedge clk);
         b_wb.ack_i = 1'b0;
         chk("rr_done", b_done, ord[i]);
         chk("rr_rdat", b_rdat, 16'h1000 + 16'(i));
      end
      b_req = 3'b000;
      @(negedge clk);

      // Reset during the second half of a split read
      b_adr[AW +: AW] = 20'h00011;
      b_req = 3'b010;
      wait_stb_b(n);
      chk("rst_split_gnt", b_gnt, 3'b010);
      b_wb.dat_i = 16'h0077;
      b_wb.ack_i = 1'b1;
      @(negedge clk);
      b_wb.ack_i = 1'b0;
      @(negedge clk);
      chk("rst_split_stb2", b_wb.stb_o, 1'b1);
      chk("rst_split_adr2", b_wb.adr_o, 20'h00012);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_stb", b_wb.stb_o, 1'b0);
      chk("async_rst_cyc", b_wb.cyc_o, 1'b0);
      chk("async_rst_gnt", b_gnt, 3'b000);
      chk("async_rst_adr", b_wb.adr_o, 20'h00000);
      chk("async_rst_rdat", b_rdat, 16'h0000);
      b_req = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      wait_stb_b(n);
      chk("post_rst_gnt", b_gnt, 3'b001);
      b_wb.dat_i = 16'h4242;
      b_wb.ack_i = 1'b1;
      @(negedge clk);
      b_wb.ack_i = 1'b0;
      chk("post_rst_done", b_done, 3'b001);
      b_req = 3'b000;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
